// File: rtl/conv3x3_filter_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// No logic here: mode encoding, fixed kernels, accumulator width helper.
// Imported by the filter top; the line buffer is type-agnostic.
package conv3x3_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_HSOBEL = 2'b01,
        MODE_VSOBEL = 2'b10,
        MODE_PROG   = 2'b11
    } mode_e;

    localparam int NTAPS = 9;

    // Row-major taps, index 0 = top-left, 8 = bottom-right.
    localparam int SOBEL_H [NTAPS] = '{-1, -2, -1,  0, 0, 0,  1, 2, 1};
    localparam int SOBEL_V [NTAPS] = '{-1,  0,  1, -2, 0, 2, -1, 0, 1};
    localparam int IDENT_K [NTAPS] = '{ 0,  0,  0,  0, 1, 0,  0, 0, 0};

    // Nine products of (data_w+1) x coef_w bits never exceed this width.
    function automatic int acc_w(input int data_w, input int coef_w);
        return data_w + coef_w + 4;
    endfunction

endpackage

// File: rtl/conv3x3_filter_if.sv
// Pixel stream + coefficient programming bundle for conv3x3_filter.
// master: upstream pixel source / register writer; slave: the filter.
// Inputs: iSOF, iDVAL, iDATA, iMODE, iCOEF_*; outputs: oDATA, oDVAL, oBORDER.
interface conv3x3_filter_if #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 4
);
    logic                     iSOF;
    logic                     iDVAL;
    logic [DATA_W-1:0]        iDATA;
    logic [1:0]               iMODE;
    logic                     iCOEF_WE;
    logic [3:0]               iCOEF_ADDR;
    logic signed [COEF_W-1:0] iCOEF_DATA;
    logic [DATA_W-1:0]        oDATA;
    logic                     oDVAL;
    logic                     oBORDER;

    modport master (
        output iSOF, iDVAL, iDATA, iMODE, iCOEF_WE, iCOEF_ADDR, iCOEF_DATA,
        input  oDATA, oDVAL, oBORDER
    );

    modport slave (
        input  iSOF, iDVAL, iDATA, iMODE, iCOEF_WE, iCOEF_ADDR, iCOEF_DATA,
        output oDATA, oDVAL, oBORDER
    );
endinterface

// File: rtl/conv3x3_filter_line_buffer.sv
// DATA_W x LINE_W shift chain; dout_o is the sample pushed LINE_W enables ago.
// Latency: LINE_W enabled cycles; holds while en_i is low.
// No backpressure; no reset so it maps onto RAM-based shift registers.
// Ports: clk_i clock, en_i shift enable, din_i sample in, dout_o oldest sample.
module conv_line_buffer #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);
    logic [DATA_W-1:0] chain_q [LINE_W];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            chain_q[0] <= din_i;
            for (int i = 1; i < LINE_W; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign dout_o = chain_q[LINE_W-1];
endmodule

// File: rtl/conv3x3_filter.sv
// Streaming 3x3 convolution (bypass / Sobel-H / Sobel-V / programmable) with border masking.
// Latency: fixed 3 cycles from iDVAL to oDVAL; one output per input pixel.
// No backpressure: the pipeline advances every cycle and never stalls.
// Ports: iCLK, iRST (async active-low), bus (slave: pixel in, coef writes, pixel/valid/border out).
module conv3x3_filter
    import conv3x3_filter_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int LINE_W    = 640,
    parameter int COEF_W    = 4,
    parameter int OUT_SHIFT = 0
) (
    input logic             iCLK,
    input logic             iRST,
    conv3x3_filter_if.slave bus
);
    localparam int ACC_W = acc_w(DATA_W, COEF_W);
    // Sobel needs +/-2, so the internal tap width is at least 3 bits.
    localparam int KC_W  = (COEF_W > 3) ? COEF_W : 3;
    localparam int COL_W = $clog2(LINE_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [ACC_W:0]   PIX_MAX  = (ACC_W + 1)'((1 << DATA_W) - 1);

    typedef logic [DATA_W-1:0]        pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [KC_W-1:0]   kc_t;

    // Line buffers: lb0 yields the row above, lb1 the row two above.
    pix_t lb0_dat, lb1_dat;

    conv_line_buffer #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_lb0 (
        .clk_i (iCLK), .en_i (bus.iDVAL), .din_i (bus.iDATA), .dout_o (lb0_dat)
    );

    conv_line_buffer #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_lb1 (
        .clk_i (iCLK), .en_i (bus.iDVAL), .din_i (lb0_dat), .dout_o (lb1_dat)
    );

    // Frame state and stage-1 registers.
    pix_t             win_q    [NTAPS], win_d [NTAPS], win_base [NTAPS];
    coef_t            shadow_q [NTAPS], shadow_d [NTAPS];
    coef_t            active_q [NTAPS], active_d [NTAPS];
    kc_t              kern1_q  [NTAPS], kern_d [NTAPS];
    logic [COL_W-1:0] col_q, col_d, col_base;
    logic [1:0]       row_q, row_d, row_base;
    mode_e            mode_q, mode_d;
    logic             sof_seen_q, sof_seen_d;
    logic             v1_q, brd1_q, byp1_q, brd_d;

    // Stage-2 / stage-3 registers.
    logic signed [ACC_W-1:0] sum_q, acc;
    logic                    v2_q, brd2_q, byp2_q;
    pix_t                    odata_q, res;
    logic                    odval_q, oborder_q;
    logic signed [ACC_W:0]   sum_x;
    logic [ACC_W:0]          mag, mag_sh;

    always_comb begin
        shadow_d = shadow_q;
        if (bus.iCOEF_WE && (bus.iCOEF_ADDR < 4'd9)) begin
            shadow_d[bus.iCOEF_ADDR] = bus.iCOEF_DATA;
        end
        // Copy after the write merge so a same-cycle write lands in the new frame.
        active_d = active_q;
        mode_d   = mode_q;
        if (bus.iSOF) begin
            active_d = shadow_d;
            mode_d   = mode_e'(bus.iMODE);
        end
        sof_seen_d = sof_seen_q | bus.iSOF;

        // iSOF clears position and window before the coincident pixel is applied.
        col_base = bus.iSOF ? '0 : col_q;
        row_base = bus.iSOF ? '0 : row_q;
        for (int i = 0; i < NTAPS; i++) begin
            win_base[i] = bus.iSOF ? '0 : win_q[i];
        end

        win_d = win_base;
        col_d = col_base;
        row_d = row_base;
        if (bus.iDVAL) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_base[3*r+1];
                win_d[3*r + 1] = win_base[3*r+2];
            end
            win_d[2] = lb1_dat;
            win_d[5] = lb0_dat;
            win_d[8] = bus.iDATA;
            if (col_base == COL_LAST) begin
                col_d = '0;
                if (row_base != 2'd2) row_d = row_base + 2'd1;
            end else begin
                col_d = col_base + COL_W'(1);
            end
        end

        // Until a frame start has been seen the row count is meaningless.
        brd_d = !sof_seen_d || (row_base < 2'd2) || (col_base < COL_W'(2));

        // Kernel travels with the sample so a frame boundary never mixes kernels in flight.
        for (int i = 0; i < NTAPS; i++) begin
            kern_d[i] = KC_W'(IDENT_K[i]);
            case (mode_d)
                MODE_HSOBEL: kern_d[i] = KC_W'(SOBEL_H[i]);
                MODE_VSOBEL: kern_d[i] = KC_W'(SOBEL_V[i]);
                MODE_PROG:   kern_d[i] = KC_W'(active_d[i]);
                default:     kern_d[i] = KC_W'(IDENT_K[i]);
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int i = 0; i < NTAPS; i++) begin
                win_q[i]    <= '0;
                shadow_q[i] <= COEF_W'(IDENT_K[i]);
                active_q[i] <= COEF_W'(IDENT_K[i]);
                kern1_q[i]  <= '0;
            end
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= MODE_BYPASS;
            sof_seen_q <= 1'b0;
            v1_q       <= 1'b0;
            brd1_q     <= 1'b0;
            byp1_q     <= 1'b0;
        end else begin
            win_q      <= win_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            kern1_q    <= kern_d;
            col_q      <= col_d;
            row_q      <= row_d;
            mode_q     <= mode_d;
            sof_seen_q <= sof_seen_d;
            v1_q       <= bus.iDVAL;
            brd1_q     <= brd_d;
            byp1_q     <= (mode_d == MODE_BYPASS);
        end
    end

    // Stage 2: signed MAC; pixels are zero-extended to DATA_W+1 signed.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAPS; i++) begin
            acc = acc + (ACC_W'(signed'({1'b0, win_q[i]})) * ACC_W'(kern1_q[i]));
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            sum_q  <= '0;
            v2_q   <= 1'b0;
            brd2_q <= 1'b0;
            byp2_q <= 1'b0;
        end else begin
            sum_q  <= acc;
            v2_q   <= v1_q;
            brd2_q <= brd1_q;
            byp2_q <= byp1_q;
        end
    end

    // Stage 3: abs in ACC_W+1 bits so the most-negative sum has a magnitude.
    // Bypass passes the centre pixel untouched by the output shift.
    always_comb begin
        sum_x  = (ACC_W + 1)'(sum_q);
        mag    = unsigned'(sum_x[ACC_W] ? -sum_x : sum_x);
        mag_sh = mag >> OUT_SHIFT;
        if (byp2_q)                res = mag[DATA_W-1:0];
        else if (mag_sh > PIX_MAX) res = '1;
        else                       res = mag_sh[DATA_W-1:0];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            odata_q   <= '0;
            odval_q   <= 1'b0;
            oborder_q <= 1'b0;
        end else begin
            odval_q <= v2_q;
            if (v2_q) begin
                oborder_q <= brd2_q;
                odata_q   <= brd2_q ? '0 : res;
            end
        end
    end

    assign bus.oDATA   = odata_q;
    assign bus.oDVAL   = odval_q;
    assign bus.oBORDER = oborder_q;
endmodule
